record_rr_arbiter: RTL and testbench

- Round-robin scheduler that shares one downstream record_t blocking port among NUM_REQ upstream producers.
- Every port uses the sync/notify blocking handshake. A transfer occurs on a rising clk edge when the port's notify and sync are both high.
- Sits between several record producers and a single record consumer. Forwards one whole record per grant and tags it with the source index.

---
 rtl/record_rr_arbiter_pkg.sv | 8 +
 rtl/shared_types_pkg.sv | 7 +
 rtl/record_rr_arbiter_rr_pick.sv | 24 ++
 rtl/record_rr_arbiter.sv | 93 +++++++++
 tb/tb_record_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/record_rr_arbiter_pkg.sv
// Types and parameter defaults for the round-robin record arbiter.
package record_arb_types;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int SRC_W_DEF   = $clog2(NUM_REQ_DEF);
  localparam int CNT_W_DEF   = 16;
endpackage

// File: rtl/shared_types_pkg.sv
// Record type shared by the record producers and consumers in this codebase.
package shared_types;
  typedef struct packed {
    logic signed [31:0] x;
    logic        [31:0] y;
  } record_t;
endpackage

// File: rtl/record_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching circularly
// from last+1.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic               any,
  output logic [SRC_W-1:0]   idx
);
  logic [SRC_W-1:0] w_j;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any = |req;
    idx = '0;
    w_j = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = SRC_W'((int'(last) + k) % NUM_REQ);
      if (req[w_j]) idx = w_j;
    end
  end
endmodule

// File: rtl/record_rr_arbiter.sv
// Round-robin arbiter sharing one sync/notify record port among NUM_REQ
// producers; forwards one whole record per grant, tagged with its source.
module record_rr_arbiter
  import shared_types::*;
  import record_arb_types::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int SRC_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  record_t [NUM_REQ-1:0]  in_data,
  input  logic    [NUM_REQ-1:0]  in_sync,
  output logic    [NUM_REQ-1:0]  in_notify,
  input  logic    [NUM_REQ-1:0]  in_mask,
  output record_t                out_data,
  output logic    [SRC_W-1:0]    out_src,
  input  logic                   out_sync,
  output logic                   out_notify,
  output logic    [CNT_W-1:0]    grant_count
);
  state_t               r_state, w_state_nxt;
  logic [SRC_W-1:0]     r_grant, r_last, r_out_src, w_pick;
  logic [NUM_REQ-1:0]   r_notify, w_eligible;
  record_t              r_out_data;
  logic                 r_out_notify, w_any, w_rd_xfer, w_wr_xfer;
  logic [CNT_W-1:0]     r_cnt;

  assign w_eligible = in_sync & in_mask;
  assign w_rd_xfer  = in_sync[r_grant] && r_notify[r_grant];
  assign w_wr_xfer  = out_sync && r_out_notify;

  rr_pick #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_pick (
    .req  (w_eligible),
    .last (r_last),
    .any  (w_any),
    .idx  (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any)     w_state_nxt = ST_READ;
      ST_READ:  if (w_rd_xfer) w_state_nxt = ST_WRITE;
      ST_WRITE: if (w_wr_xfer) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // last resets to NUM_REQ-1 so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant      <= '0;
      r_last       <= SRC_W'(NUM_REQ - 1);
      r_notify     <= '0;
      r_out_data   <= '0;
      r_out_src    <= '0;
      r_out_notify <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_grant  <= w_pick;
          r_notify <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
        end
        ST_READ: if (w_rd_xfer) begin
          r_out_data   <= in_data[r_grant];
          r_out_src    <= r_grant;
          r_notify     <= '0;
          r_out_notify <= 1'b1;
        end
        ST_WRITE: if (w_wr_xfer) begin
          r_out_notify <= 1'b0;
          r_last       <= r_grant;
          r_cnt        <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_notify   = r_notify;
  assign out_data    = r_out_data;
  assign out_src     = r_out_src;
  assign out_notify  = r_out_notify;
  assign grant_count = r_cnt;
endmodule

// File: tb/tb_record_rr_arbiter.sv
// Scoreboard bench for record_rr_arbiter (NUM_REQ=4, CNT_W=4).
module tb_record_rr_arbiter;
  import shared_types::*;

  localparam int N  = 4;
  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst;
  record_t [N-1:0]    in_data;
  logic    [N-1:0]    in_sync, in_notify, in_mask;
  record_t            out_data;
  logic    [1:0]      out_src;
  logic               out_sync, out_notify;
  logic    [CW-1:0]   grant_count;

  typedef struct {
    record_t    d;
    logic [1:0] src;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rem[N];
  int   seq[N];

  always #5 clk = ~clk;

  record_rr_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_sync     (in_sync),
    .in_notify   (in_notify),
    .in_mask     (in_mask),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_sync    (out_sync),
    .out_notify  (out_notify),
    .grant_count (grant_count)
  );

  function automatic record_t rec(int i, int s);
    record_t r;
    r.x = 32'(-(i * 1000 + s + 1));
    r.y = 32'hC0DE0000 ^ 32'(i << 12) ^ 32'(s);
    return r;
  endfunction

  function automatic exp_t mk(int i, int s);
    exp_t e;
    e.d   = rec(i, s);
    e.src = 2'(i);
    return e;
  endfunction

  // Output side: every accepted record is popped and compared.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && out_notify === 1'b1 && out_sync === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got src=%0d x=%0d y=%h, required no output",
                 out_src, out_data.x, out_data.y);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.d || out_src !== e.src) begin
          n_bad++;
          $display("FAIL sb_data: got src=%0d x=%0d y=%h, required src=%0d x=%0d y=%h",
                   out_src, out_data.x, out_data.y, e.src, e.d.x, e.d.y);
        end
      end
    end
  end

  // One clock; producers advance their data and drop sync once exhausted.
  task automatic tick();
    logic [N-1:0] x;
    @(negedge clk);
    x = in_sync & in_notify;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        rem[i]--;
        seq[i]++;
        in_data[i] = rec(i, seq[i]);
        if (rem[i] <= 0) in_sync[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_sync  = '0;
    in_mask  = '1;
    out_sync = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 0;
      in_data[i] = rec(i, 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(int lim, string name);
    for (int k = 0; k < lim && sb.size() > 0; k++) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d records outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_sync  = '0;
    in_mask  = '1;
    out_sync = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = rec(i, 0);
    @(negedge clk);
    n_cmp++;
    if (in_notify !== 4'b0000) begin n_bad++; $display("FAIL rst_in_notify: got %b, required 0000", in_notify); end
    n_cmp++;
    if (out_notify !== 1'b0) begin n_bad++; $display("FAIL rst_out_notify: got %b, required 0", out_notify); end
    n_cmp++;
    if (out_data !== 64'd0 || out_src !== 2'd0) begin
      n_bad++; $display("FAIL rst_out_data: got %h/%0d, required 0/0", out_data, out_src);
    end
    n_cmp++;
    if (grant_count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d, required 0", grant_count); end
  endtask

  task automatic test_single();
    record_t r;
    exp_t e;
    do_reset();
    r.x = -32'sd5;
    r.y = 32'hDEADBEEF;
    in_data[0] = r;
    rem[0] = 1;
    in_sync = 4'b0001;
    out_sync = 1'b1;
    e.d = r; e.src = 2'd0;
    sb.push_back(e);
    tick();
    n_cmp++;
    if (in_notify !== 4'b0001 || out_notify !== 1'b0) begin
      n_bad++; $display("FAIL single_grant: got notify=%b out_notify=%b, required 0001/0", in_notify, out_notify);
    end
    tick();
    n_cmp++;
    if (in_notify !== 4'b0000 || out_notify !== 1'b1) begin
      n_bad++; $display("FAIL single_read: got notify=%b out_notify=%b, required 0000/1", in_notify, out_notify);
    end
    tick();
    n_cmp++;
    if (out_notify !== 1'b0 || grant_count !== 4'd1) begin
      n_bad++; $display("FAIL single_write: got out_notify=%b count=%0d, required 0/1", out_notify, grant_count);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 1;
      sb.push_back(mk(i, 0));
    end
    in_sync  = 4'b1111;
    out_sync = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_cmp++;
      if (out_notify !== ((k % 3) == 2)) begin
        n_bad++; $display("FAIL rr_cadence: cycle %0d out_notify=%b, required %b", k, out_notify, (k % 3) == 2);
      end
    end
    n_cmp++;
    if (grant_count !== 4'd4 || sb.size() != 0) begin
      n_bad++; $display("FAIL rr_count: got count=%0d left=%0d, required 4/0", grant_count, sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rem[2] = 1;
    in_sync = 4'b0100;
    sb.push_back(mk(2, 0));
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (out_notify !== 1'b1 || out_src !== 2'd2 || out_data !== rec(2, 0) || in_notify !== 4'b0000) begin
        n_bad++;
        $display("FAIL bp_hold: cycle %0d got on=%b src=%0d data=%h notify=%b, required 1/2/%h/0000",
                 k, out_notify, out_src, out_data, in_notify, rec(2, 0));
      end
    end
    out_sync = 1'b1;
    tick();
    n_cmp++;
    if (out_notify !== 1'b0 || grant_count !== 4'd1 || sb.size() != 0) begin
      n_bad++; $display("FAIL bp_release: got on=%b count=%0d left=%0d, required 0/1/0", out_notify, grant_count, sb.size());
    end
  endtask

  task automatic test_mask();
    bit seen;
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 2;
    in_mask  = 4'b1010;
    in_sync  = 4'b1111;
    out_sync = 1'b1;
    sb.push_back(mk(1, 0));
    sb.push_back(mk(3, 0));
    sb.push_back(mk(1, 1));
    sb.push_back(mk(3, 1));
    wait_drain(40, "mask");
    n_cmp++;
    if (rem[0] != 2 || rem[2] != 2 || grant_count !== 4'd4) begin
      n_bad++; $display("FAIL mask_excluded: got rem0=%0d rem2=%0d count=%0d, required 2/2/4", rem[0], rem[2], grant_count);
    end
    // Clearing the mask after the grant must not abort the transfer.
    do_reset();
    rem[1]   = 1;
    in_mask  = 4'b0010;
    in_sync  = 4'b0010;
    out_sync = 1'b1;
    sb.push_back(mk(1, 0));
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      tick();
      seen = in_notify[1];
    end
    in_mask = 4'b0000;
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL mask_grant: got notify=%b, required 0010", in_notify); end
    wait_drain(10, "mask_clear");
    n_cmp++;
    if (grant_count !== 4'd1) begin n_bad++; $display("FAIL mask_clear_count: got %0d, required 1", grant_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rem[1]   = 1;
    in_sync  = 4'b0010;
    out_sync = 1'b1;
    sb.push_back(mk(1, 0));
    wait_drain(20, "mid_pre");
    out_sync  = 1'b0;
    rem[2]    = 5;
    in_sync[2] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_notify !== 1'b1 || out_src !== 2'd2 || grant_count !== 4'd1) begin
      n_bad++; $display("FAIL mid_write: got on=%b src=%0d count=%0d, required 1/2/1", out_notify, out_src, grant_count);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_notify !== 1'b0 || grant_count !== 4'd0 || in_notify !== 4'b0000) begin
      n_bad++; $display("FAIL mid_reset: got on=%b count=%0d notify=%b, required 0/0/0000", out_notify, grant_count, in_notify);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    rem[0]     = 1;
    rem[2]     = 1;
    in_sync[0] = 1'b1;
    out_sync   = 1'b1;
    sb.push_back(mk(0, 0));
    sb.push_back(mk(2, 1));
    tick();
    n_cmp++;
    if (in_notify !== 4'b0001) begin n_bad++; $display("FAIL mid_priority: got %b, required 0001", in_notify); end
    wait_drain(20, "mid_post");
    n_cmp++;
    if (grant_count !== 4'd2) begin n_bad++; $display("FAIL mid_count: got %0d, required 2", grant_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    rem[0]   = 17;
    in_sync  = 4'b0001;
    out_sync = 1'b1;
    for (int s = 0; s < 17; s++) sb.push_back(mk(0, s));
    wait_drain(17 * 3 + 10, "wrap");
    n_cmp++;
    if (grant_count !== 4'd1) begin n_bad++; $display("FAIL wrap_count: got %0d, required 1", grant_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
